// File: rtl/tft_pkg.sv
// Shared definitions for the TFT SPI receive path: ILI9341 command codes,
// decoder state encoding and pixel width.
package tft_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int unsigned RGB565_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_SKIP
  } dec_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the bus into clk, detects rising
// spi_clk edges while selected and assembles MSB-first bytes.
module spi_byte_rx
  import tft_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       spi_clk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_dc_i,
  input  logic       spi_cs_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_dc_o
);

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, dc_q, cs_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   valid_q, valid_d;
  logic [7:0]             data_q, data_d;
  logic                   bdc_q, bdc_d;
  logic                   sclk_s, mosi_s, dc_s, cs_s, sample;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign dc_s   = dc_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];

  // An edge arriving in the same cycle cs rises is still taken, so a byte
  // whose last edge coincides with deselect completes before the clear.
  assign sample = sclk_s & ~sclk_prev_q & (~cs_s | ~cs_prev_q);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    data_d  = data_q;
    bdc_d   = bdc_q;
    if (sample) begin
      shift_d = {shift_q[6:0], mosi_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        valid_d = 1'b1;
        data_d  = shift_d;
        bdc_d   = dc_s;
        cnt_d   = '0;
      end
    end
    if (cs_s) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_q      <= '0;
      mosi_q      <= '0;
      dc_q        <= '0;
      cs_q        <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      bdc_q       <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_clk_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
      dc_q        <= {dc_q[SYNC_STAGES-2:0], spi_dc_i};
      cs_q        <= {cs_q[SYNC_STAGES-2:0], spi_cs_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      bdc_q       <= bdc_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign byte_dc_o    = bdc_q;

endmodule

// File: rtl/tft_spi_decoder.sv
// Panel-side model of the TFT SPI link: receives bytes and decodes
// CASET/PASET/RAMWR into addressed RGB565 pixel writes.
module tft_spi_decoder
  import tft_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PANEL_W     = 240,
  parameter int unsigned PANEL_H     = 320
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_clk,
  input  logic                spi_mosi,
  input  logic                spi_dc,
  input  logic                spi_cs,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                byte_dc,
  output logic                cmd_valid,
  output logic [7:0]          cmd_code,
  output logic                pix_valid,
  output logic [15:0]         pix_x,
  output logic [15:0]         pix_y,
  output logic [RGB565_W-1:0] pix_color
);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Asynchronous assert, synchronous release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic       rx_valid, rx_dc;
  logic [7:0] rx_data;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .spi_clk_i    (spi_clk),
    .spi_mosi_i   (spi_mosi),
    .spi_dc_i     (spi_dc),
    .spi_cs_i     (spi_cs),
    .byte_valid_o (rx_valid),
    .byte_data_o  (rx_data),
    .byte_dc_o    (rx_dc)
  );

  dec_state_e          state_q, state_d;
  logic [1:0]          pcnt_q, pcnt_d;
  logic [23:0]         shadow_q, shadow_d;
  logic [15:0]         xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0]         x_q, x_d, y_q, y_d;
  logic [7:0]          hi_q, hi_d;
  logic                cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d;
  logic [7:0]          cmd_code_q, cmd_code_d;
  logic [15:0]         pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [RGB565_W-1:0] pix_color_q, pix_color_d;

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    shadow_d    = shadow_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_d        = hi_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    if (rx_valid && !rx_dc) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = rx_data;
      pcnt_d      = '0;
      case (rx_data)
        CMD_CASET: state_d = ST_CASET;
        CMD_PASET: state_d = ST_PASET;
        CMD_RAMWR: begin
          state_d = ST_RAMWR_HI;
          x_d     = xs_q;
          y_d     = ys_q;
        end
        default:   state_d = ST_SKIP;
      endcase
    end else if (rx_valid) begin
      case (state_q)
        ST_CASET, ST_PASET: begin
          pcnt_d = pcnt_q + 2'd1;
          // Shadow holds start_hi, start_lo, end_hi; end_lo arrives live.
          if (pcnt_q == 2'd3) begin
            if (state_q == ST_CASET) begin
              xs_d = shadow_q[23:8];
              xe_d = {shadow_q[7:0], rx_data};
            end else begin
              ys_d = shadow_q[23:8];
              ye_d = {shadow_q[7:0], rx_data};
            end
            state_d = ST_IDLE;
          end else begin
            shadow_d = {shadow_q[15:0], rx_data};
          end
        end
        ST_RAMWR_HI: begin
          hi_d    = rx_data;
          state_d = ST_RAMWR_LO;
        end
        ST_RAMWR_LO: begin
          pix_valid_d = 1'b1;
          pix_x_d     = x_q;
          pix_y_d     = y_q;
          pix_color_d = {hi_q, rx_data};
          if (x_q == xe_q) begin
            x_d = xs_q;
            y_d = (y_q == ye_q) ? ys_q : y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
          state_d = ST_RAMWR_HI;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pcnt_q      <= '0;
      shadow_q    <= '0;
      xs_q        <= '0;
      xe_q        <= 16'(PANEL_W - 1);
      ys_q        <= '0;
      ye_q        <= 16'(PANEL_H - 1);
      x_q         <= '0;
      y_q         <= '0;
      hi_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      shadow_q    <= shadow_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hi_q        <= hi_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
    end
  end

  assign byte_valid = rx_valid;
  assign byte_data  = rx_data;
  assign byte_dc    = rx_dc;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_color  = pix_color_q;

endmodule
